mdu_iter_seq: RTL and testbench
===============================

// Module: mdu_iter_seq
// PURPOSE
//  Multi-cycle RV32M execution unit: accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//  request per handshake and returns one 32-bit result. Radix-2 shift-add multiply and
//  restoring divide. Sits in the execute stage as the area-lean alternative to the
//  single-cycle integer math block; the pipeline stalls on o_ready/o_valid.
// PARAMETERS
//  WIDTH      32  operand/result width; even, >=8
//  FAST_DIV0   1  1: div-by-zero and signed overflow complete in 1 cycle; 0: full iteration
// PORTS
//  i_clk       in   1      clock; all state changes on rising edge
//  i_reset_n   in   1      reset, synchronous, active-low
//  i_kill      in   1      pipeline flush; aborts the operation in flight
//  i_valid     in   1      request valid
//  o_ready     out  1      unit can accept a request (state IDLE)
//  i_funct3    in   3      RV32M funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  i_op1       in   WIDTH  rs1 value (multiplicand / dividend)
//  i_op2       in   WIDTH  rs2 value (multiplier / divisor)
//  o_valid     out  1      result valid; held until accepted
//  i_ready     in   1      consumer accepts result
//  o_result    out  WIDTH  result
// BEHAVIOUR
//  Reset (i_reset_n=0 at edge): state IDLE, o_valid=0, o_result=0, counter=0; o_ready=1 after.
//   Applies from any state, mid-operation included; request in flight is discarded.
//  FSM: IDLE -> PREP -> CALC -> FIX -> DONE -> IDLE.
//   IDLE: o_ready=1. Accept on i_valid&&o_ready (cycle T): latch funct3, operands.
//   PREP (T+1): op1_signed = funct3 in {1,2,4,6}; op2_signed = funct3 in {1,4,6}.
//    Take magnitudes of signed-negative operands; record neg_res (mul: sign1^sign2;
//    div quotient: sign1^sign2; rem: sign1). Clear accumulator; counter=WIDTH-1.
//   CALC (T+2..T+WIDTH+1): one bit per cycle, counter decrements; exit when counter==0.
//    Mul: 2*WIDTH-bit product, add multiplicand when multiplier LSB=1, shift right.
//    Div: shift {rem,quot} left, trial-subtract divisor, set quotient bit when rem>=divisor.
//   FIX (T+WIDTH+2): negate (two's complement) result if neg_res. Select:
//    MUL low WIDTH bits; MULH/MULHSU/MULHU high WIDTH bits; DIV/DIVU quotient; REM/REMU remainder.
//   DONE: o_valid=1 from T+WIDTH+3 (latency WIDTH+3 = 35 for WIDTH=32); o_result stable.
//    Leave to IDLE on i_ready; o_valid=0 and o_ready=1 the next cycle.
//    No new request accepted in the cycle the result is taken.
//  Special cases (RISC-V defined, no traps):
//   divisor==0: DIV/DIVU quotient = all ones; REM/REMU = i_op1.
//   DIV/REM signed with op1=-2^(WIDTH-1), op2=-1: quotient = op1, remainder = 0.
//   FAST_DIV0=1: detected at accept, IDLE->DONE, o_valid at T+1.
//   FAST_DIV0=0: full iteration; FIX produces the same values.
//  i_kill: state -> IDLE at the next edge from any state, DONE included; o_valid=0 next cycle;
//   result lost. i_kill in IDLE with i_valid: request not accepted.
//   i_kill has priority over i_ready and i_valid.
//  i_valid, i_funct3 and operands are ignored while o_ready=0; latched copies only are used.
//  o_result changes only on entry to DONE.
// TESTING
//  MUL 7*-3: funct3=0, op1=7, op2=32'hFFFF_FFFD -> o_valid at T+35, result 32'hFFFF_FFEB.
//  MULH/MULHSU/MULHU, op1=op2=32'hFFFF_FFFF -> 0, 32'hFFFF_FFFF, 32'hFFFF_FFFE.
//  DIV -7/2 = 32'hFFFF_FFFD; REM -7/2 = 32'hFFFF_FFFF; DIVU 100/7 = 14; REMU = 2.
//  DIV by 0 (op1=5) -> 32'hFFFF_FFFF at T+1; REM by 0 -> 5;
//   DIV 32'h8000_0000/-1 -> 32'h8000_0000; REM -> 0.
//  Backpressure: i_ready=0 for 10 cycles in DONE -> o_valid and o_result held;
//   i_ready=1 -> o_valid=0 and o_ready=1 the next cycle.
//  i_kill at T+10, or i_reset_n=0 at T+10 -> IDLE next cycle, no o_valid;
//   back-to-back request then gives a correct result.

Source files
------------

// File: rtl/mdu_iter_seq.sv
`default_nettype none
// ============================================================================
// Module   : mdu_iter_seq
// Brief    : Iterative RV32M multiply/divide unit (radix-2 shift-add, restoring divide)
// Revision : 1.0
// ============================================================================
module mdu_iter_seq #(
    parameter int WIDTH     = 32,
    parameter bit FAST_DIV0 = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_kill,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_funct3,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [2:0]       funct3;
    logic [WIDTH-1:0] op1, op2;
    logic [WIDTH-1:0] mcand, hi, lo;
    logic [CW-1:0]    count;
    logic             neg_q, neg_r;

    // Fast-path detection works on the raw request so it can finish at accept.
    logic             req_div0, req_ovf, fast_take;
    logic [WIDTH-1:0] fast_result;

    assign req_div0 = (i_op2 == '0);
    assign req_ovf  = !i_funct3[0] && (i_op1 == {1'b1, {(WIDTH-1){1'b0}}}) && (i_op2 == '1);

    generate
        if (FAST_DIV0) begin : g_fast
            assign fast_take   = i_funct3[2] && (req_div0 || req_ovf);
            assign fast_result = i_funct3[1] ? (req_div0 ? i_op1 : '0)
                                             : (req_div0 ? '1 : i_op1);
        end else begin : g_slow
            assign fast_take   = 1'b0;
            assign fast_result = '0;
        end
    endgenerate

    logic             is_div, op1_signed, op2_signed, sign1, sign2, div0;
    logic [WIDTH-1:0] mag1, mag2;

    assign is_div     = funct3[2];
    assign op1_signed = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
    assign op2_signed = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    assign sign1      = op1_signed && op1[WIDTH-1];
    assign sign2      = op2_signed && op2[WIDTH-1];
    assign mag1       = sign1 ? -op1 : op1;
    assign mag2       = sign2 ? -op2 : op2;
    assign div0       = (op2 == '0);

    // One iteration step; divide keeps an extra bit since rem*2 can exceed WIDTH bits.
    logic [WIDTH:0] mul_sum, div_sh, div_diff;
    logic           div_ge;

    assign mul_sum  = {1'b0, hi} + {1'b0, (lo[0] ? mcand : {WIDTH{1'b0}})};
    assign div_sh   = {hi, lo[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, mcand};
    assign div_ge   = !div_diff[WIDTH];

    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, fix_result;

    assign prod     = {hi, lo};
    assign prod_fix = neg_q ? -prod : prod;
    assign quot_fix = neg_q ? -lo : lo;
    assign rem_fix  = neg_r ? -hi : hi;

    always_comb begin
        fix_result = '0;
        case (funct3)
            3'd0:       fix_result = prod_fix[WIDTH-1:0];
            3'd1, 3'd2,
            3'd3:       fix_result = prod_fix[2*WIDTH-1:WIDTH];
            3'd4, 3'd5: fix_result = div0 ? '1 : quot_fix;
            default:    fix_result = div0 ? op1 : rem_fix;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) state <= S_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_valid) state_nxt = fast_take ? S_DONE : S_PREP;
            S_PREP:  state_nxt = S_CALC;
            S_CALC:  if (count == '0) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  if (i_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (i_kill) state_nxt = S_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            funct3   <= '0;
            op1      <= '0;
            op2      <= '0;
            mcand    <= '0;
            hi       <= '0;
            lo       <= '0;
            count    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            o_result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_valid && !i_kill) begin
                        funct3 <= i_funct3;
                        op1    <= i_op1;
                        op2    <= i_op2;
                        if (fast_take) o_result <= fast_result;
                    end
                end
                S_PREP: begin
                    mcand <= is_div ? mag2 : mag1;
                    lo    <= is_div ? mag1 : mag2;
                    hi    <= '0;
                    neg_q <= sign1 ^ sign2;
                    neg_r <= sign1;
                    count <= CW'(WIDTH - 1);
                end
                S_CALC: begin
                    if (is_div) begin
                        hi <= div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
                        lo <= {lo[WIDTH-2:0], div_ge};
                    end else begin
                        {hi, lo} <= {mul_sum, lo[WIDTH-1:1]};
                    end
                    if (count != '0) count <= count - CW'(1);
                end
                S_FIX: begin
                    if (!i_kill) o_result <= fix_result;
                end
                default: ;
            endcase
        end
    end

    assign o_ready = (state == S_IDLE);
    assign o_valid = (state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_iter_seq
// Brief    : Randomized bench for mdu_iter_seq against a latency/arithmetic model
// Revision : 1.0
// ============================================================================
module tb_mdu_iter_seq;

    localparam int W    = 32;
    localparam bit FAST = 1'b1;
    localparam int LAT  = W + 3;

    logic        clk = 1'b0;
    logic        reset_n, kill, valid, ready;
    logic [2:0]  f3;
    logic [31:0] op1, op2;
    logic        o_ready, o_valid;
    logic [31:0] o_result;

    always #5 clk = ~clk;

    mdu_iter_seq #(.WIDTH(W), .FAST_DIV0(FAST)) dut (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_kill    (kill),
        .i_valid   (valid),
        .o_ready   (o_ready),
        .i_funct3  (f3),
        .i_op1     (op1),
        .i_op2     (op2),
        .o_valid   (o_valid),
        .i_ready   (ready),
        .o_result  (o_result)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    bit          pending  = 1'b0;
    int          left     = 0;
    logic [31:0] exp_res  = '0;
    logic [31:0] last_res = '0;
    bit          mon_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        case (f)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : 32'(ua % ub);
        endcase
    endfunction

    function automatic bit is_spec(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Advance one clock and update the model from the inputs seen at that edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!reset_n) begin
            pending  = 1'b0;
            left     = 0;
            last_res = '0;
        end else if (kill) begin
            pending = 1'b0;
        end else if (!pending) begin
            if (valid) begin
                pending = 1'b1;
                exp_res = ref_result(f3, op1, op2);
                left    = (FAST && is_spec(f3, op1, op2)) ? 0 : LAT - 1;
                if (left == 0) last_res = exp_res;
            end
        end else if (left > 0) begin
            left--;
            if (left == 0) last_res = exp_res;
        end else if (ready) begin
            pending = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("o_ready", {31'b0, o_ready}, {31'b0, !pending});
            chk("o_valid", {31'b0, o_valid}, {31'b0, pending && left == 0});
            chk("o_result", o_result, last_res);
        end
    end

    task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int kill_at, input int rst_at, input int rdy_delay,
                        input bit noise, input bit use_lit, input logic [31:0] lit);
        int n, done_cyc;
        bit seen;
        valid = 1'b1; f3 = f; op1 = a; op2 = b;
        kill = 1'b0; reset_n = 1'b1; ready = 1'b0;
        tick();
        valid = 1'b0;
        n = 1; done_cyc = 0; seen = 1'b0;
        while (pending) begin
            if (n > 200) begin
                n_checks++;
                $display("FAIL timeout: op still pending after %0d cycles, expected completion", n);
                break;
            end
            kill    = (n == kill_at);
            reset_n = !(n == rst_at);
            if (noise) begin
                valid = 1'($urandom_range(0, 1));
                f3    = 3'($urandom);
                op1   = $urandom;
                op2   = $urandom;
            end
            if (left == 0) begin
                if (use_lit && !seen) begin
                    chk("lit_result", o_result, lit);
                    seen = 1'b1;
                end
                ready = (done_cyc >= rdy_delay);
                done_cyc++;
            end else begin
                ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            tick();
            n++;
        end
        valid = 1'b0; kill = 1'b0; reset_n = 1'b1; ready = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset_n = 1'b0; kill = 1'b0; valid = 1'b0; ready = 1'b0;
        f3 = '0; op1 = '0; op2 = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        chk("reset_ready", {31'b0, o_ready}, 32'd1);
        chk("reset_valid", {31'b0, o_valid}, 32'd0);
        chk("reset_result", o_result, 32'd0);
        mon_en = 1'b1;

        send(3'd0, 32'd7, 32'hFFFF_FFFD, -1, -1, 0, 0, 1, 32'hFFFF_FFEB);
        send(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, 0, 0, 1, 32'h0);
        send(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, 0, 0, 1, 32'hFFFF_FFFF);
        send(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, 0, 0, 1, 32'hFFFF_FFFE);
        send(3'd4, 32'hFFFF_FFF9, 32'd2, -1, -1, 0, 0, 1, 32'hFFFF_FFFD);
        send(3'd6, 32'hFFFF_FFF9, 32'd2, -1, -1, 0, 0, 1, 32'hFFFF_FFFF);
        send(3'd5, 32'd100, 32'd7, -1, -1, 0, 0, 1, 32'd14);
        send(3'd7, 32'd100, 32'd7, -1, -1, 0, 0, 1, 32'd2);
        send(3'd4, 32'd5, 32'd0, -1, -1, 0, 0, 1, 32'hFFFF_FFFF);
        send(3'd6, 32'd5, 32'd0, -1, -1, 0, 0, 1, 32'd5);
        send(3'd5, 32'd9, 32'd0, -1, -1, 0, 0, 1, 32'hFFFF_FFFF);
        send(3'd7, 32'd9, 32'd0, -1, -1, 0, 0, 1, 32'd9);
        send(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, 0, 0, 1, 32'h8000_0000);
        send(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, 0, 0, 1, 32'h0);

        // Backpressure in DONE, then kill / reset mid-operation with back-to-back follow-ups.
        send(3'd0, 32'd7, 32'hFFFF_FFFD, -1, -1, 10, 0, 1, 32'hFFFF_FFEB);
        send(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 10, -1, 0, 0, 0, 32'h0);
        send(3'd4, 32'hFFFF_FFF9, 32'd2, -1, -1, 0, 0, 1, 32'hFFFF_FFFD);
        send(3'd7, 32'd100, 32'd7, -1, 10, 0, 0, 0, 32'h0);
        send(3'd5, 32'd100, 32'd7, -1, -1, 0, 0, 1, 32'd14);
        send(3'd1, 32'h8000_0000, 32'h8000_0000, LAT + 2, -1, 5, 0, 0, 32'h0);
        send(3'd4, 32'd5, 32'd0, 2, -1, 5, 0, 0, 32'h0);

        // Kill together with a request in IDLE: must not be accepted.
        valid = 1'b1; kill = 1'b1; f3 = 3'd0; op1 = 32'd3; op2 = 32'd4;
        tick();
        valid = 1'b0; kill = 1'b0;
        tick();
        chk("kill_idle_ready", {31'b0, o_ready}, 32'd1);

        for (int i = 0; i < 80; i++) begin
            int ka, ra;
            ka = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, LAT + 3)) : -1;
            ra = ($urandom_range(0, 11) == 0) ? int'($urandom_range(1, LAT + 3)) : -1;
            send(3'($urandom_range(0, 7)), pick(), pick(), ka, ra,
                 int'($urandom_range(0, 4)), 1, 0, 32'h0);
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (2) tick();
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
